// File: rtl/dcache_pkg.sv
// Shared types for the write-back data-cache controller.
// State encoding and the default-geometry beat index type.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_COMPARE   = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } state_type;

  localparam int DEF_WORDS = 4;
  localparam int DEF_IDX_W = $clog2(DEF_WORDS);

  typedef logic [DEF_IDX_W-1:0] beat_idx_t;

endpackage

// File: rtl/dcache_if.sv
// Pipeline/memory side bundle of the data-cache controller.
// slave = controller view, master = driver of requests and acks.
interface dcache_if #(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  logic             cpu_req;
  logic             cpu_we;
  logic             hit;
  logic             dirty;
  logic             mem_ack;
  logic             pc_stall;
  logic             mem_rd;
  logic             mem_wr;
  logic             addr_sel_victim;
  logic [IDX_W-1:0] beat_idx;
  logic             update;
  logic             tag_wr;
  logic             set_dirty;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport slave (
    input  cpu_req, cpu_we, hit, dirty, mem_ack,
    output pc_stall, mem_rd, mem_wr,
    output addr_sel_victim, beat_idx,
    output update, tag_wr, set_dirty,
    output hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_we, hit, dirty, mem_ack,
    input  pc_stall, mem_rd, mem_wr,
    input  addr_sel_victim, beat_idx,
    input  update, tag_wr, set_dirty,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/dcache_beat_ctr.sv
// Line beat counter shared by the write-back and allocate bursts.
// Wraps naturally because WORDS is a power of two.
module dcache_beat_ctr #(
  parameter int WORDS = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [$clog2(WORDS)-1:0] cnt_o,
  output logic                     last_o
);

  localparam int W = $clog2(WORDS);
  localparam logic [W-1:0] LAST = W'(WORDS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back D-cache controller: hit compare, victim write-back,
// line allocate and tag refill, with saturating hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
) (
  input  logic     CLK,
  input  logic     RST,
  dcache_if.slave  bus
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  state_type        state_q;
  state_type        state_d;
  logic [IDX_W-1:0] beat;
  logic             last;
  logic             clr;
  logic             inc;
  logic             hit_inc;
  logic             miss_inc;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  always_comb begin
    state_d             = state_q;
    clr                 = 1'b0;
    inc                 = 1'b0;
    hit_inc             = 1'b0;
    miss_inc            = 1'b0;
    bus.pc_stall        = 1'b0;
    bus.mem_rd          = 1'b0;
    bus.mem_wr          = 1'b0;
    bus.addr_sel_victim = 1'b0;
    bus.update          = 1'b0;
    bus.tag_wr          = 1'b0;
    bus.set_dirty       = 1'b0;
    case (state_q)
      ST_COMPARE: begin
        if (bus.cpu_req && bus.hit) begin
          hit_inc       = 1'b1;
          bus.set_dirty = bus.cpu_we;
        end else if (bus.cpu_req) begin
          bus.pc_stall = 1'b1;
          miss_inc     = 1'b1;
          clr          = 1'b1;
          state_d      = bus.dirty ? ST_WRITEBACK
                                   : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        bus.pc_stall        = 1'b1;
        bus.mem_wr          = 1'b1;
        bus.addr_sel_victim = 1'b1;
        if (bus.mem_ack) begin
          inc = 1'b1;
          if (last) begin
            clr     = 1'b1;
            state_d = ST_ALLOCATE;
          end
        end
      end
      ST_ALLOCATE: begin
        bus.pc_stall = 1'b1;
        bus.mem_rd   = 1'b1;
        if (bus.mem_ack) begin
          bus.update = 1'b1;
          inc        = 1'b1;
          if (last) begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        bus.pc_stall = 1'b1;
        bus.tag_wr   = 1'b1;
        state_d      = ST_COMPARE;
      end
      default: begin
        state_d = ST_COMPARE;
      end
    endcase
  end

  dcache_beat_ctr #(
    .WORDS (WORDS_PER_LINE)
  ) u_beat (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  (clr),
    .inc_i  (inc),
    .cnt_o  (beat),
    .last_o (last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_COMPARE;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hit_inc && (hit_q != '1)) begin
        hit_q <= hit_q + 1'b1;
      end
      if (miss_inc && (miss_q != '1)) begin
        miss_q <= miss_q + 1'b1;
      end
    end
  end

  assign bus.beat_idx   = beat;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

endmodule
